// File: rtl/audio_ctrl_pkg.sv
// Shared constants and the stereo-pair type for the audio controller.
package audio_ctrl_pkg;
  localparam int AUDIO_DATA_WIDTH = 32;
  localparam int FIFO_DEPTH       = 4;
  localparam int XCK_HALF         = 2;
  localparam int BCLK_HALF        = 8;
  localparam int BITS_PER_CH      = 32;

  // Bit positions in the free-running frame counter: XCK, BCLK, slot index, LRCK.
  localparam int XCK_BIT  = $clog2(XCK_HALF);
  localparam int BCLK_BIT = $clog2(BCLK_HALF);
  localparam int SLOT_W   = $clog2(BITS_PER_CH);
  localparam int CNT_W    = BCLK_BIT + 1 + SLOT_W + 1;

  typedef struct packed {
    logic [BITS_PER_CH-1:0] left;
    logic [BITS_PER_CH-1:0] right;
  } stereo_t;
endpackage

// File: rtl/audio_fifo.sv
// Synchronous show-ahead stereo FIFO with registered empty/full and a flush input.
module audio_fifo
  import audio_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    clear_i,
  input  logic    push_i,
  input  logic    pop_i,
  input  stereo_t wdata_i,
  output stereo_t rdata_o,
  output logic    empty_o,
  output logic    full_o
);
  localparam int AW = $clog2(DEPTH);

  stereo_t       mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          empty_q, full_q, push_ok, pop_ok;

  // A pop on empty is honoured only alongside a push (the pair passes straight through).
  assign pop_ok  = pop_i & (~empty_q | push_i);
  assign push_ok = push_i & (~full_q | pop_ok);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = empty_q ? '0 : mem_q[rd_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;
endmodule

// File: rtl/audio_controller.sv
// Codec-slave audio controller: XCK/BCLK/LRCK dividers, left-justified DAC/ADC shifters, stereo FIFOs.
// Define AUDIO_CTRL_ADC_EN to build the ADC capture path and input FIFO.
module audio_controller #(
  parameter int AUDIO_DATA_WIDTH = audio_ctrl_pkg::AUDIO_DATA_WIDTH,
  parameter int FIFO_DEPTH       = audio_ctrl_pkg::FIFO_DEPTH
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        clear_audio_in_memory,
  input  logic                        read_audio_in,
  input  logic                        clear_audio_out_memory,
  input  logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio_out,
  input  logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio_out,
  input  logic                        write_audio_out,
  input  logic                        AUD_ADCDAT,
  inout  wire                         AUD_BCLK,
  inout  wire                         AUD_ADCLRCK,
  inout  wire                         AUD_DACLRCK,
  output logic                        audio_in_available,
  output logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio_in,
  output logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio_in,
  output logic                        audio_out_allowed,
  output logic                        AUD_XCK,
  output logic                        AUD_DACDAT
);
  import audio_ctrl_pkg::*;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot, bit_idx;
  logic              lrck, frame_end;
  stereo_t           dac_q, dac_d;

  // One counter spans a whole frame; every codec clock is a bit of it.
  assign cnt_d     = cnt_q + CNT_W'(1);
  assign lrck      = cnt_q[CNT_W-1];
  assign slot      = cnt_q[CNT_W-2:BCLK_BIT+1];
  assign bit_idx   = ~slot;
  assign frame_end = &cnt_q;

  assign AUD_XCK     = cnt_q[XCK_BIT];
  assign AUD_BCLK    = cnt_q[BCLK_BIT];
  assign AUD_ADCLRCK = lrck;
  assign AUD_DACLRCK = lrck;
  assign AUD_DACDAT  = lrck ? dac_q.right[bit_idx] : dac_q.left[bit_idx];

  logic    out_empty, out_full, out_push, out_take;
  stereo_t out_wdata, out_head;

  assign out_wdata         = '{left: left_channel_audio_out, right: right_channel_audio_out};
  assign out_push          = write_audio_out & ~out_full;
  assign out_take          = frame_end & ~clear_audio_out_memory & (~out_empty | out_push);
  assign audio_out_allowed = ~out_full;

  audio_fifo #(.DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .clear_i (clear_audio_out_memory),
    .push_i  (out_push),
    .pop_i   (frame_end),
    .wdata_i (out_wdata),
    .rdata_o (out_head),
    .empty_o (out_empty),
    .full_o  (out_full)
  );

  // Frame start latches the next pair; underrun or a same-cycle flush plays silence.
  always_comb begin
    dac_d = dac_q;
    if (frame_end) dac_d = out_take ? (out_empty ? out_wdata : out_head) : '0;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      dac_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dac_q <= dac_d;
    end
  end

`ifdef AUDIO_CTRL_ADC_EN
  logic [BITS_PER_CH-1:0] adc_sh_q, adc_sh_d, adc_left_q, adc_left_d, adc_word;
  logic                   adc_sample, adc_last, in_push, in_pop, in_empty, in_full;
  stereo_t                in_head;

  // Sample on the cycle BCLK rises; the 32nd right bit completes the pair.
  assign adc_sample = (cnt_q[BCLK_BIT:0] == (BCLK_BIT+1)'(BCLK_HALF-1));
  assign adc_last   = adc_sample & (&slot);
  assign adc_word   = {adc_sh_q[BITS_PER_CH-2:0], AUD_ADCDAT};
  assign in_push    = adc_last & lrck;
  assign in_pop     = read_audio_in & ~in_empty;

  always_comb begin
    adc_sh_d   = adc_sh_q;
    adc_left_d = adc_left_q;
    if (adc_sample) begin
      adc_sh_d = adc_word;
      if (adc_last && !lrck) adc_left_d = adc_word;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      adc_sh_q   <= '0;
      adc_left_q <= '0;
    end else begin
      adc_sh_q   <= adc_sh_d;
      adc_left_q <= adc_left_d;
    end
  end

  audio_fifo #(.DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .clear_i (clear_audio_in_memory),
    .push_i  (in_push),
    .pop_i   (in_pop),
    .wdata_i ('{left: adc_left_q, right: adc_word}),
    .rdata_o (in_head),
    .empty_o (in_empty),
    .full_o  (in_full)
  );

  logic unused_in_full;
  assign unused_in_full        = in_full;
  assign audio_in_available    = ~in_empty;
  assign left_channel_audio_in  = in_head.left;
  assign right_channel_audio_in = in_head.right;
`else
  logic unused_adc;
  assign unused_adc             = ^{read_audio_in, clear_audio_in_memory, AUD_ADCDAT};
  assign audio_in_available     = 1'b0;
  assign left_channel_audio_in  = '0;
  assign right_channel_audio_in = '0;
`endif
endmodule

// File: tb/tb_audio_controller.sv
// Bench for audio_controller: frame-level reference model plus directed literal checks and random traffic.
module tb_audio_controller;
  localparam int FRAME = 1024;
  localparam int DEPTH = 4;
  localparam int END_N = 20480;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        clear_audio_in_memory, read_audio_in, clear_audio_out_memory;
  logic [31:0] left_channel_audio_out, right_channel_audio_out;
  logic        write_audio_out, AUD_ADCDAT;
  wire         AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK;
  logic        audio_in_available, audio_out_allowed, AUD_XCK, AUD_DACDAT;
  logic [31:0] left_channel_audio_in, right_channel_audio_in;

  audio_controller dut (
    .CLOCK_50               (CLOCK_50),
    .reset                  (reset),
    .clear_audio_in_memory  (clear_audio_in_memory),
    .read_audio_in          (read_audio_in),
    .clear_audio_out_memory (clear_audio_out_memory),
    .left_channel_audio_out (left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out),
    .write_audio_out        (write_audio_out),
    .AUD_ADCDAT             (AUD_ADCDAT),
    .AUD_BCLK               (AUD_BCLK),
    .AUD_ADCLRCK            (AUD_ADCLRCK),
    .AUD_DACLRCK            (AUD_DACLRCK),
    .audio_in_available     (audio_in_available),
    .left_channel_audio_in  (left_channel_audio_in),
    .right_channel_audio_in (right_channel_audio_in),
    .audio_out_allowed      (audio_out_allowed),
    .AUD_XCK                (AUD_XCK),
    .AUD_DACDAT             (AUD_DACDAT)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int          tests = 0;
  int          fails = 0;
  int          n = 0;
  bit          run = 0;
  logic [31:0] adc_l, adc_r;
  logic [63:0] oq[$];
  logic [63:0] iq[$];
  logic [63:0] play = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at n=%0d: got %h expected %h", nm, n, act, exp);
    end
  endtask

  // Reference model: n is the number of clock edges since reset release.
  always @(posedge CLOCK_50) begin
    if (reset) begin
      oq.delete();
      iq.delete();
      play = '0;
      n = 0;
    end else begin
      if (clear_audio_out_memory) oq.delete();
      else if (write_audio_out && oq.size() < DEPTH)
        oq.push_back({left_channel_audio_out, right_channel_audio_out});
      if (n % FRAME == FRAME - 1)
        play = (!clear_audio_out_memory && oq.size() > 0) ? oq.pop_front() : 64'h0;
`ifdef AUDIO_CTRL_ADC_EN
      if (clear_audio_in_memory) iq.delete();
      else begin
        if (read_audio_in && iq.size() > 0) void'(iq.pop_front());
        if (n % FRAME == FRAME - 9 && iq.size() < DEPTH) iq.push_back({adc_l, adc_r});
      end
`endif
      n++;
    end
  end

  // Compare every cycle once out of reset.
  always @(negedge CLOCK_50) begin
    logic [31:0] dw;
    logic [63:0] head;
    if (run && !reset) begin
      dw   = ((n / 512) % 2 == 1) ? play[31:0] : play[63:32];
      head = (iq.size() > 0) ? iq[0] : 64'h0;
      chk("xck",     64'(AUD_XCK),     64'((n / 2) % 2));
      chk("bclk",    64'(AUD_BCLK),    64'((n / 8) % 2));
      chk("adclrck", 64'(AUD_ADCLRCK), 64'((n / 512) % 2));
      chk("daclrck", 64'(AUD_DACLRCK), 64'((n / 512) % 2));
      chk("dacdat",  64'(AUD_DACDAT),  64'(dw[31 - (n % 512) / 16]));
      chk("allowed", 64'(audio_out_allowed), 64'(oq.size() < DEPTH));
      chk("avail",   64'(audio_in_available), 64'(iq.size() > 0));
      chk("in_data", {left_channel_audio_in, right_channel_audio_in}, head);
    end
  end

  logic [63:0] dbits = '0;
  int          zacc = 0;

  task automatic drive();
    logic [31:0] w;
    write_audio_out        = 1'b0;
    read_audio_in          = 1'b0;
    clear_audio_in_memory  = 1'b0;
    clear_audio_out_memory = 1'b0;
    if (n > 0 && n % FRAME == 0) begin
      adc_l = $urandom;
      adc_r = $urandom;
    end
    w = ((n / 512) % 2 == 1) ? adc_r : adc_l;
    AUD_ADCDAT = w[31 - (n % 512) / 16];

    if (n == 1) chk("lit_xck_n1", 64'(AUD_XCK), 64'd0);
    if (n == 2) chk("lit_xck_n2", 64'(AUD_XCK), 64'd1);
    if (n == 7) chk("lit_bclk_n7", 64'(AUD_BCLK), 64'd0);
    if (n == 8) chk("lit_bclk_rise", 64'(AUD_BCLK), 64'd1);
    if (n == 511) chk("lit_lrck_n511", 64'(AUD_DACLRCK), 64'd0);
    if (n == 512) chk("lit_lrck_n512", 64'(AUD_DACLRCK), 64'd1);
    if (n == 1024) chk("lit_lrck_n1024", 64'(AUD_ADCLRCK), 64'd0);

    if (n == 5) begin
      write_audio_out         = 1'b1;
      left_channel_audio_out  = 32'hA5A50001;
      right_channel_audio_out = 32'h80000000;
    end
    if (n == 1020) begin
`ifdef AUDIO_CTRL_ADC_EN
      chk("lit_adc_avail", 64'(audio_in_available), 64'd1);
      chk("lit_adc_pair", {left_channel_audio_in, right_channel_audio_in}, 64'h12345678_9ABCDEF0);
`else
      chk("lit_noadc_avail", 64'(audio_in_available), 64'd0);
      chk("lit_noadc_pair", {left_channel_audio_in, right_channel_audio_in}, 64'h0);
`endif
      read_audio_in = 1'b1;
    end
    if (n == 1022) chk("lit_avail_after_read", 64'(audio_in_available), 64'd0);
    if (n >= 1024 && n < 2048 && n % 16 == 8) dbits = {dbits[62:0], AUD_DACDAT};
    if (n == 2048) chk("lit_dac_pair", dbits, 64'hA5A50001_80000000);

    if (n >= 1100 && n <= 1104) begin
      write_audio_out         = 1'b1;
      left_channel_audio_out  = 32'h1000_0000 + 32'(n);
      right_channel_audio_out = 32'h2000_0000 + 32'(n);
    end
    if (n == 1106) chk("lit_full", 64'(audio_out_allowed), 64'd0);
    if (n == 2046) chk("lit_full_pre_edge", 64'(audio_out_allowed), 64'd0);
    if (n == 2050) chk("lit_allowed_post_edge", 64'(audio_out_allowed), 64'd1);

    if (n == 6200 || n == 6201) begin
      write_audio_out         = 1'b1;
      left_channel_audio_out  = $urandom | 32'h1;
      right_channel_audio_out = $urandom | 32'h1;
    end
    if (n == 6300) clear_audio_out_memory = 1'b1;
    if (n == 6302) chk("lit_allowed_after_clear", 64'(audio_out_allowed), 64'd1);
    if (n >= 6144 && n < 8192 && AUD_DACDAT) zacc++;
    if (n == 8192) chk("lit_silent_frames", 64'(zacc), 64'd0);

    if (n >= 8192) begin
      write_audio_out         = ((n / 2048) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                                      : ($urandom_range(0, 599) == 0);
      left_channel_audio_out  = $urandom;
      right_channel_audio_out = $urandom;
      read_audio_in           = ($urandom_range(0, 199) == 0);
      clear_audio_in_memory   = ($urandom_range(0, 3999) == 0);
      clear_audio_out_memory  = ($urandom_range(0, 4999) == 0);
    end
  endtask

  initial begin
    reset                   = 1'b1;
    clear_audio_in_memory   = 1'b0;
    read_audio_in           = 1'b0;
    clear_audio_out_memory  = 1'b0;
    write_audio_out         = 1'b0;
    left_channel_audio_out  = '0;
    right_channel_audio_out = '0;
    AUD_ADCDAT              = 1'b0;
    adc_l                   = 32'h12345678;
    adc_r                   = 32'h9ABCDEF0;
    repeat (5) @(negedge CLOCK_50);
    chk("rst_xck",     64'(AUD_XCK), 64'd0);
    chk("rst_bclk",    64'(AUD_BCLK), 64'd0);
    chk("rst_adclrck", 64'(AUD_ADCLRCK), 64'd0);
    chk("rst_daclrck", 64'(AUD_DACLRCK), 64'd0);
    chk("rst_dacdat",  64'(AUD_DACDAT), 64'd0);
    chk("rst_avail",   64'(audio_in_available), 64'd0);
    chk("rst_allowed", 64'(audio_out_allowed), 64'd1);
    chk("rst_in_data", {left_channel_audio_in, right_channel_audio_in}, 64'h0);
    reset = 1'b0;
    run   = 1'b1;
    while (n < END_N) begin
      drive();
      @(negedge CLOCK_50);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/audio_controller.md
AUDIO_CONTROLLER -- requirements
Module: audio_controller

Interface
REQ-001 Param AUDIO_DATA_WIDTH, 32, bits per channel sample; width is fixed at 32.
REQ-002 Param FIFO_DEPTH, 4, stereo-pair entries per direction; must be a power of 2.
REQ-003 CLOCK_50  in  1  sole clock, 50 MHz.
REQ-004 reset  in  1  reset, asynchronous and active-high.
REQ-005 clear_audio_in_memory  in  1  flush input FIFO; 0 when left unconnected.
REQ-006 read_audio_in  in  1  pop one input pair.
REQ-007 clear_audio_out_memory  in  1  flush output FIFO; 0 when left unconnected.
REQ-008 left_channel_audio_out / right_channel_audio_out  in  32 each  pair to play.
REQ-009 write_audio_out  in  1  push one output pair.
REQ-010 AUD_ADCDAT  in  1  codec ADC serial data.
REQ-011 AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK  inout  1 each  always driven (codec slave).
REQ-012 audio_in_available  out  1  input FIFO not empty.
REQ-013 left_channel_audio_in / right_channel_audio_in  out  32 each  head of input FIFO (show-ahead).
REQ-014 audio_out_allowed  out  1  output FIFO not full.
REQ-015 AUD_XCK, AUD_DACDAT  out  1 each  codec master clock, DAC serial data.

Function
REQ-016 AUD_XCK toggles every 2 CLOCK_50 cycles: 12.5 MHz.
REQ-017 AUD_BCLK toggles every 8 cycles: period 16 cycles, 3.125 MHz.
REQ-018 AUD_DACLRCK = AUD_ADCLRCK; both toggle on a BCLK falling edge every 32 BCLK periods (1024-cycle frame, ~48.8 kHz); low = left.
REQ-019 Format: left-justified, MSB first; bit 31 is valid on the same BCLK falling edge that toggles LRCK.
REQ-020 AUD_DACDAT changes only on BCLK falling edges; AUD_ADCDAT is sampled on BCLK rising edges.
REQ-021 At each LRCK 1->0 edge, pop one pair from a non-empty output FIFO and shift it out, left then right; an empty FIFO sends 32'h0 for both channels (underrun, no error flag).
REQ-022 After the 32nd right-channel ADC bit, push the assembled pair to the input FIFO; if the FIFO is full, the new pair is dropped.
REQ-023 write_audio_out while audio_out_allowed=1 pushes both channels in that cycle; it is ignored while audio_out_allowed=0.
REQ-024 read_audio_in while audio_in_available=1 pops one pair; it is ignored while audio_in_available=0.
REQ-025 Push and pop in the same cycle on a full or empty FIFO are both honoured; occupancy is unchanged.
REQ-026 clear_* empties its FIFO on the next clock edge and overrides a simultaneous push or pop; the serializer word in flight completes.
REQ-027 Status flags are registered and update the cycle after the push or pop.

Reset
REQ-028 During reset: AUD_XCK, BCLK, LRCKs, AUD_DACDAT = 0; FIFOs empty; audio_in_available = 0; audio_out_allowed = 1; audio_in data = 0.
REQ-029 After reset release, dividers start from 0; the first frame is left, and BCLK's first rise is 8 cycles after release.

Configuration
REQ-030 Macro AUDIO_CTRL_ADC_EN defined: ADC capture path and input FIFO are present.
REQ-031 Macro AUDIO_CTRL_ADC_EN absent: no input FIFO; audio_in_available = 0, audio_in data = 0, read and clear-in are ignored; DAC path is unchanged.

Structure
REQ-032 Package audio_ctrl_pkg holds AUDIO_DATA_WIDTH, FIFO_DEPTH, XCK_HALF=2, BCLK_HALF=8, BITS_PER_CH=32 and a stereo-pair typedef (64-bit struct).
REQ-033 One sub-module, audio_fifo (synchronous, show-ahead, full/empty, clear), is instantiated once per direction.

Verification
REQ-034 Assert reset for 5 cycles -> all outputs per REQ-028; release -> XCK period 4, BCLK period 16, LRCK period 1024 cycles.
REQ-035 Write L=32'hA5A50001, R=32'h80000000 -> in the next frame, DACDAT serializes A5A50001 MSB-first while LRCK=0, then 80000000 while LRCK=1.
REQ-036 Drive ADCDAT with L=32'h12345678, R=32'h9ABCDEF0 -> audio_in_available=1 after the right word; audio_in shows that pair; read -> available=0.
REQ-037 Four writes with no frame boundary -> audio_out_allowed=0; fifth write is ignored; after the next LRCK 1->0 edge, allowed=1; the played sequence shows 4 pairs.
REQ-038 Empty output FIFO -> DACDAT=0 for a full frame; fill 2 pairs, pulse clear_audio_out_memory -> allowed=1, next frame plays zeros.
REQ-039 Compile without AUDIO_CTRL_ADC_EN and toggle ADCDAT -> audio_in_available stays 0 and audio_in data stays 0.
